// File: rtl/mul_pkg.sv
// -----------------------------------------------------------------------------
// mul_pkg
// Shared definitions for the sequential shift-and-add multiplier:
//   - default operand width and the derived iteration counter width
//   - controller state encoding (IDLE / RUN)
//   - helper for sizing the iteration counter of other widths
// Optional feature macro used by the importing files: MUL_EARLY_TERM_EN
// -----------------------------------------------------------------------------
package mul_pkg;

  localparam int MUL_WIDTH = 8;
  localparam int MUL_CNT_W = $clog2(MUL_WIDTH);

  // Controller state encoding, kept as plain constants so the state register
  // stays a simple vector in every tool flow.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Named view of the same encoding for debug and waveform readability.
  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN
  } state_e;

  // A 1-bit operand would otherwise yield a zero-width counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/mul_datapath.sv
// -----------------------------------------------------------------------------
// mul_datapath
// Register set and adder for the shift-and-add multiplier. Holds the shifted
// multiplicand, the shifted-down multiplier and the running accumulator.
//
// Ports:
//   clk         system clock, rising-edge active
//   rst         asynchronous active-low reset, clears all registers
//   load        capture a/b and clear the accumulator
//   step        perform one partial-product iteration
//   a, b        multiplicand / multiplier operands (unsigned)
//   sum         accumulator value after this cycle's conditional addition
//   early_done  remaining multiplier bits are all zero after this iteration
//
// Macro MUL_EARLY_TERM_EN: when defined, early_done reports that the
// multiplier being shifted in is zero; otherwise it is tied low.
// -----------------------------------------------------------------------------
module mul_datapath
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] sum,
  output logic               early_done
);

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;

  // sum is also what the controller writes to answer on the final iteration,
  // so the last partial product is never lost.
  assign sum = mplier[0] ? (acc + mcand) : acc;

`ifdef MUL_EARLY_TERM_EN
  assign early_done = ((mplier >> 1) == '0);
`else
  assign early_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/seq_mul8x8.sv
// -----------------------------------------------------------------------------
// seq_mul8x8
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier. A rising edge on
// st captures a and b; one partial product is accumulated per clock and the
// 2*WIDTH-bit product is registered on answer when the operation completes.
// answer keeps the previous product while an operation is in flight.
//
// Ports:
//   clk     system clock, rising-edge active
//   rst     asynchronous active-low reset
//   st      start request, rising-edge detected
//   a       multiplicand, unsigned
//   b       multiplier, unsigned
//   answer  registered product of the last completed operation
//
// Macro MUL_EARLY_TERM_EN: when defined, an operation finishes as soon as the
// remaining multiplier bits are zero (1..WIDTH cycles). Undefined: always
// exactly WIDTH iterations.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for a rising edge on st; answer holds last product
// RUN     | one iteration per clock; last iteration writes answer
// -----------------------------------------------------------------------------
module seq_mul8x8
  import mul_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               st,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] answer
);

  localparam int               CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

  logic [0:0]         state;
  logic               st_q;
  logic [CNT_W-1:0]   count;
  logic               start;
  logic               load;
  logic               step;
  logic               last_iter;
  logic               early_done;
  logic               done;
  logic [2*WIDTH-1:0] sum;

  // st_q follows st in every state, so a start pulse seen during RUN is
  // consumed there and cannot fire later.
  assign start     = st & ~st_q;
  assign load      = (state == ST_IDLE) && start;
  assign step      = (state == ST_RUN);
  assign last_iter = (count == LAST);
  assign done      = step && (last_iter || early_done);

  mul_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .step       (step),
    .a          (a),
    .b          (b),
    .sum        (sum),
    .early_done (early_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      st_q   <= 1'b0;
      count  <= '0;
      answer <= '0;
    end else begin
      st_q <= st;
      case (state)
        ST_IDLE: begin
          if (start) begin
            count <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          count <= count + CNT_W'(1);
          if (done) begin
            answer <= sum;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul8x8.sv
// -----------------------------------------------------------------------------
// tb_seq_mul8x8
// Self-checking bench for seq_mul8x8. Expected products come from plain
// integer multiplication; expected completion cycle comes from the operand
// (fixed 8, or MSB position + 1 when MUL_EARLY_TERM_EN is defined).
// -----------------------------------------------------------------------------
module tb_seq_mul8x8;

  logic        clk;
  logic        rst;
  logic        st;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] answer;

  int total = 0;
  int bad   = 0;

  logic [15:0] model_ans;
  logic [15:0] trace [0:31];

  int         chg_cycle   = 0;
  logic [7:0] chg_a       = 8'h00;
  logic [7:0] chg_b       = 8'h00;
  int         pulse_cycle = 0;
  bit         hold_st     = 1'b0;

  seq_mul8x8 dut (
    .clk    (clk),
    .rst    (rst),
    .st     (st),
    .a      (a),
    .b      (b),
    .answer (answer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] prod_of(input logic [7:0] av, input logic [7:0] bv);
    int p;
    p = int'(av) * int'(bv);
    return p[15:0];
  endfunction

  // Cycles from acceptance until answer shows the new product.
  function automatic int lat_of(input logic [7:0] bv);
    int l;
    l = 8;
`ifdef MUL_EARLY_TERM_EN
    l = 1;
    for (int i = 0; i < 8; i++) if (bv[i]) l = i + 1;
`endif
    return l;
  endfunction

  // Called positioned just after a falling edge. Presents the operands with
  // st high for the acceptance edge, then records answer after each of the
  // following ncyc rising edges (trace[k] = value after edge E<k>).
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv, input int ncyc);
    a  = av;
    b  = bv;
    st = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= ncyc; k++) begin
      if (k == chg_cycle) begin
        a = chg_a;
        b = chg_b;
      end
      st = hold_st || (k == pulse_cycle);
      @(posedge clk);
      @(negedge clk);
      trace[k] = answer;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    st  = 1'b0;
    a   = 8'h00;
    b   = 8'h00;
    #1;
    total++;
    if (answer !== 16'h0000) begin
      bad++;
      $display("FAIL reset_value got=%h exp=0000", answer);
    end
    @(negedge clk);
    rst = 1'b1;
    a   = 8'h5A;
    b   = 8'hC3;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (answer !== 16'h0000) begin
        bad++;
        $display("FAIL idle_no_activity cyc=%0d got=%h exp=0000", k, answer);
      end
    end
    model_ans = 16'h0000;
  endtask

  task automatic test_basic;
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    p = prod_of(8'h12, 8'h13);
    l = lat_of(8'h13);
    do_op(8'h12, 8'h13, 12);
    for (int k = 1; k <= 12; k++) begin
      exp_v = (k >= l) ? p : model_ans;
      total++;
      if (trace[k] !== exp_v) begin
        bad++;
        $display("FAIL basic cyc=%0d got=%h exp=%h", k, trace[k], exp_v);
      end
    end
    total++;
    if (trace[12] !== 16'h0156) begin
      bad++;
      $display("FAIL basic_const got=%h exp=0156", trace[12]);
    end
    model_ans = p;
  endtask

  task automatic test_operand_change;
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    p = prod_of(8'h12, 8'h13);
    l = lat_of(8'h13);
    chg_cycle = 3;
    chg_a     = 8'h23;
    chg_b     = 8'h12;
    do_op(8'h12, 8'h13, 12);
    chg_cycle = 0;
    for (int k = 1; k <= 12; k++) begin
      exp_v = (k >= l) ? p : model_ans;
      total++;
      if (trace[k] !== exp_v) begin
        bad++;
        $display("FAIL operand_change cyc=%0d got=%h exp=%h", k, trace[k], exp_v);
      end
    end
    model_ans = p;
    p = prod_of(8'h23, 8'h12);
    l = lat_of(8'h12);
    do_op(8'h23, 8'h12, 12);
    for (int k = 1; k <= 12; k++) begin
      exp_v = (k >= l) ? p : model_ans;
      total++;
      if (trace[k] !== exp_v) begin
        bad++;
        $display("FAIL restart_after_change cyc=%0d got=%h exp=%h", k, trace[k], exp_v);
      end
    end
    total++;
    if (trace[12] !== 16'h0276) begin
      bad++;
      $display("FAIL restart_const got=%h exp=0276", trace[12]);
    end
    model_ans = p;
  endtask

  task automatic test_start_in_run;
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    p = prod_of(8'h9D, 8'hC3);
    l = lat_of(8'hC3);
    pulse_cycle = 3;
    chg_cycle   = 3;
    chg_a       = 8'h77;
    chg_b       = 8'h99;
    do_op(8'h9D, 8'hC3, 20);
    pulse_cycle = 0;
    chg_cycle   = 0;
    for (int k = 1; k <= 20; k++) begin
      exp_v = (k >= l) ? p : model_ans;
      total++;
      if (trace[k] !== exp_v) begin
        bad++;
        $display("FAIL start_in_run cyc=%0d got=%h exp=%h", k, trace[k], exp_v);
      end
    end
    model_ans = p;
  endtask

  task automatic test_hold_st;
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    p = prod_of(8'hE7, 8'h6B);
    l = lat_of(8'h6B);
    hold_st   = 1'b1;
    chg_cycle = 10;
    chg_a     = 8'h0F;
    chg_b     = 8'h0E;
    do_op(8'hE7, 8'h6B, 20);
    hold_st   = 1'b0;
    chg_cycle = 0;
    for (int k = 1; k <= 20; k++) begin
      exp_v = (k >= l) ? p : model_ans;
      total++;
      if (trace[k] !== exp_v) begin
        bad++;
        $display("FAIL hold_st cyc=%0d got=%h exp=%h", k, trace[k], exp_v);
      end
    end
    st = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (answer !== p) begin
        bad++;
        $display("FAIL hold_st_release cyc=%0d got=%h exp=%h", k, answer, p);
      end
    end
    model_ans = p;
  endtask

  task automatic test_reset_mid_run;
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    do_op(8'hFF, 8'hC3, 3);
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (answer !== 16'h0000) begin
      bad++;
      $display("FAIL reset_async got=%h exp=0000", answer);
    end
    model_ans = 16'h0000;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      total++;
      if (answer !== 16'h0000) begin
        bad++;
        $display("FAIL reset_abort cyc=%0d got=%h exp=0000", k, answer);
      end
    end
    p = prod_of(8'h23, 8'h12);
    l = lat_of(8'h12);
    do_op(8'h23, 8'h12, 12);
    for (int k = 1; k <= 12; k++) begin
      exp_v = (k >= l) ? p : model_ans;
      total++;
      if (trace[k] !== exp_v) begin
        bad++;
        $display("FAIL after_reset_op cyc=%0d got=%h exp=%h", k, trace[k], exp_v);
      end
    end
    model_ans = p;
  endtask

  // st already high when reset releases: the first edge must accept.
  task automatic test_start_after_reset;
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    rst = 1'b0;
    st  = 1'b1;
    a   = 8'h0B;
    b   = 8'h0D;
    @(negedge clk);
    total++;
    if (answer !== 16'h0000) begin
      bad++;
      $display("FAIL reset_hold got=%h exp=0000", answer);
    end
    model_ans = 16'h0000;
    rst = 1'b1;
    p = prod_of(8'h0B, 8'h0D);
    l = lat_of(8'h0D);
    do_op(8'h0B, 8'h0D, 12);
    for (int k = 1; k <= 12; k++) begin
      exp_v = (k >= l) ? p : model_ans;
      total++;
      if (trace[k] !== exp_v) begin
        bad++;
        $display("FAIL start_after_reset cyc=%0d got=%h exp=%h", k, trace[k], exp_v);
      end
    end
    model_ans = p;
  endtask

  task automatic test_boundaries;
    logic [7:0]  av [0:5];
    logic [7:0]  bv [0:5];
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    av[0] = 8'hFF; bv[0] = 8'hFF;
    av[1] = 8'h00; bv[1] = 8'hA5;
    av[2] = 8'h01; bv[2] = 8'h80;
    av[3] = 8'h5A; bv[3] = 8'h01;
    av[4] = 8'h37; bv[4] = 8'h80;
    av[5] = 8'hC4; bv[5] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      p = prod_of(av[i], bv[i]);
      l = lat_of(bv[i]);
      do_op(av[i], bv[i], 10);
      for (int k = 1; k <= 10; k++) begin
        exp_v = (k >= l) ? p : model_ans;
        total++;
        if (trace[k] !== exp_v) begin
          bad++;
          $display("FAIL boundary a=%h b=%h cyc=%0d got=%h exp=%h",
                   av[i], bv[i], k, trace[k], exp_v);
        end
      end
      model_ans = p;
    end
  endtask

  // Each new start lands on the first edge after completion.
  task automatic test_back_to_back;
    logic [7:0]  av;
    logic [7:0]  bv;
    logic [15:0] p;
    logic [15:0] exp_v;
    int l;
    for (int i = 0; i < 30; i++) begin
      av = 8'($urandom_range(0, 255));
      bv = (i % 7 == 3) ? 8'h00 : 8'($urandom_range(0, 255));
      p  = prod_of(av, bv);
      l  = lat_of(bv);
      do_op(av, bv, l);
      for (int k = 1; k <= l; k++) begin
        exp_v = (k >= l) ? p : model_ans;
        total++;
        if (trace[k] !== exp_v) begin
          bad++;
          $display("FAIL back_to_back op=%0d a=%h b=%h cyc=%0d got=%h exp=%h",
                   i, av, bv, k, trace[k], exp_v);
        end
      end
      model_ans = p;
    end
    st = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand_change();
    test_start_in_run();
    test_hold_st();
    test_reset_mid_run();
    test_start_after_reset();
    test_boundaries();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
